// File: rtl/fadd_arbiter_pkg.sv
// Shared types and constants for the FP-add arbiter.
//   state_t  : arbiter FSM states
//   FLAG_*   : 2-bit result status codes
//   QNAN_32  : result returned when the adder never answers
package fadd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0]  FLAG_REGULAR   = 2'b00;
  localparam logic [1:0]  FLAG_OVERFLOW  = 2'b01;
  localparam logic [1:0]  FLAG_UNDERFLOW = 2'b10;
  localparam logic [1:0]  FLAG_INVALID   = 2'b11;
  localparam logic [31:0] QNAN_32        = 32'h7FC0_0000;

endpackage

// File: rtl/fadd_arbiter_if.sv
// Requester + adder bus of the FP-add arbiter.
//   req_valid/req_x/req_y/req_ready : per-requester operation request
//   rsp_valid/rsp_ready/rsp_z/rsp_flag : per-requester result return
//   fu_start/fu_x/fu_y/fu_done/fu_z/fu_flag : external adder link
// slave = arbiter side, master = requesters and adder side.
interface fadd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][31:0] req_x;
  logic [N_REQ-1:0][31:0] req_y;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [31:0]            rsp_z;
  logic [1:0]             rsp_flag;
  logic                   fu_start;
  logic [31:0]            fu_x;
  logic [31:0]            fu_y;
  logic                   fu_done;
  logic [31:0]            fu_z;
  logic [1:0]             fu_flag;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready, fu_done, fu_z, fu_flag,
    output req_ready, rsp_valid, rsp_z, rsp_flag, fu_start, fu_x, fu_y
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready, fu_done, fu_z, fu_flag,
    input  req_ready, rsp_valid, rsp_z, rsp_flag, fu_start, fu_x, fu_y
  );
endinterface

// File: rtl/fadd_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req        : request vector
//   last_grant : index granted last
//   gnt        : one-hot grant (zero when no request)
//   gnt_idx    : index of gnt
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  logic [IDX_W-1:0] p;

  // Scan offsets from farthest to nearest; the nearest hit after
  // last_grant is written last and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    p       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      p = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        gnt_idx = p;
      end
    end
  end
endmodule

// File: rtl/fadd_arbiter.sv
// Shares one external FP adder between N_REQ requesters, one op at a time.
//   clk, rst    : clock, async active-low reset
//   bus         : requester/response/adder signals (slave side)
//   busy        : FSM not in IDLE
//   timeout_err : sticky, set when the adder fails to answer in time
//   ops_done    : wrapping count of completed responses
module fadd_arbiter
  import fadd_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  fadd_arbiter_if.slave bus,
  output logic          busy,
  output logic          timeout_err,
  output logic [15:0]   ops_done
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] gidx;
  logic [N_REQ-1:0] gnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_hs;
  logic             to_hit;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gidx)
  );

  // Grant only from IDLE and never while reset is held.
  assign bus.req_ready = (state == IDLE && rst) ? gnt : '0;
  assign busy          = (state != IDLE);
  // rsp_valid is one-hot on the granted index, so other rsp_ready bits drop out.
  assign rsp_hs        = |(bus.rsp_valid & bus.rsp_ready);
  // This cycle's increment brings the counter to TIMEOUT-1.
  assign to_hit        = (wait_cnt == CNT_W'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant    <= IDX_W'(N_REQ - 1);
      cur           <= '0;
      wait_cnt      <= '0;
      bus.fu_start  <= 1'b0;
      bus.fu_x      <= '0;
      bus.fu_y      <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_z     <= '0;
      bus.rsp_flag  <= FLAG_REGULAR;
      timeout_err   <= 1'b0;
      ops_done      <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          cur          <= gidx;
          bus.fu_x     <= bus.req_x[gidx];
          bus.fu_y     <= bus.req_y[gidx];
          bus.fu_start <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          bus.fu_start <= 1'b0;
          wait_cnt     <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.fu_done) begin
            // adder answer beats a coincident timeout
            bus.rsp_z     <= bus.fu_z;
            bus.rsp_flag  <= bus.fu_flag;
            bus.rsp_valid <= ONE << cur;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (to_hit) begin
              bus.rsp_z     <= QNAN_32;
              bus.rsp_flag  <= FLAG_INVALID;
              bus.rsp_valid <= ONE << cur;
              timeout_err   <= 1'b1;
              state         <= RESP;
            end
          end
        end
        RESP: if (rsp_hs) begin
          bus.rsp_valid <= '0;
          last_grant    <= cur;
          ops_done      <= ops_done + 16'd1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fadd_arbiter.sv
module tb_fadd_arbiter;
  localparam int TO = 16;

  typedef struct {
    bit          rst_b;   // pulse reset before this vector
    logic [3:0]  mask;    // req_valid pattern held for the op
    logic [31:0] x, y;    // operands of the expected winner
    int          k;       // adder latency (0: never answers)
    logic [31:0] fz;      // adder result
    logic [1:0]  ff;      // adder flag
    logic [31:0] ez;      // expected rsp_z
    logic [1:0]  ef;      // expected rsp_flag
    int          idx;     // expected grant index
    int          lat;     // expected accept->rsp_valid cycles
    int          bp;      // cycles of withheld rsp_ready
    logic [15:0] ops;     // expected ops_done after handshake
    bit          terr;    // expected timeout_err in RESP
  } vec_t;

  logic clk, rst;
  logic busy, timeout_err;
  logic [15:0] ops_done;
  int nvec, nerr;
  int fu_k, pend, nstart;
  logic [31:0] fu_ret_z;
  logic [1:0]  fu_ret_flag;
  vec_t vt[17];

  fadd_arbiter_if #(.N_REQ(4)) bus ();

  fadd_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err),
    .ops_done    (ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder model: fu_done k-1 cycles after the fu_start cycle.
  initial begin
    pend = 0; nstart = 0;
    bus.fu_done = 1'b0; bus.fu_z = 32'hBAD0_BAD0; bus.fu_flag = 2'b01;
    forever begin
      @(posedge clk); #1;
      bus.fu_done = 1'b0; bus.fu_z = 32'hBAD0_BAD0; bus.fu_flag = 2'b01;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.fu_done = 1'b1; bus.fu_z = fu_ret_z; bus.fu_flag = fu_ret_flag;
        end
      end
      if (bus.fu_start === 1'b1) begin
        nstart++;
        if (fu_k > 0) pend = fu_k - 1;
      end
    end
  end

  task automatic nxt;
    @(posedge clk); #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    bus.req_valid = 4'b1111; bus.rsp_ready = 4'b0000;
    rst = 1'b0; #1;
    chk("rst req_ready", 32'(bus.req_ready), 0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst fu_start",  32'(bus.fu_start), 0);
    chk("rst fu_x",      bus.fu_x, 0);
    chk("rst fu_y",      bus.fu_y, 0);
    chk("rst rsp_z",     bus.rsp_z, 0);
    chk("rst rsp_flag",  32'(bus.rsp_flag), 0);
    chk("rst busy",      32'(busy), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    chk("rst ops_done",  32'(ops_done), 0);
    nxt;
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    nxt;
  endtask

  task automatic do_op(input vec_t v);
    logic [3:0] oh;
    int off, s0;
    oh = 4'b0001 << v.idx;
    for (int i = 0; i < 4; i++) begin
      bus.req_x[i] = (i == v.idx) ? v.x : (32'hDEAD_0000 | 32'(i));
      bus.req_y[i] = (i == v.idx) ? v.y : (32'hBEEF_0000 | 32'(i));
    end
    fu_k = v.k; fu_ret_z = v.fz; fu_ret_flag = v.ff; s0 = nstart;
    bus.req_valid = v.mask; #1;
    chk("accept req_ready", 32'(bus.req_ready), 32'(oh));
    nxt;
    chk("issue fu_start", 32'(bus.fu_start), 1);
    chk("issue fu_x", bus.fu_x, v.x);
    chk("issue fu_y", bus.fu_y, v.y);
    chk("issue busy", 32'(busy), 1);
    chk("issue req_ready", 32'(bus.req_ready), 0);
    off = 1;
    while (bus.rsp_valid == 4'b0000 && off < 200) begin
      nxt; off++;
    end
    chk("latency", 32'(off), 32'(v.lat));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
    chk("rsp_z", bus.rsp_z, v.ez);
    chk("rsp_flag", 32'(bus.rsp_flag), 32'(v.ef));
    chk("timeout_err", 32'(timeout_err), 32'(v.terr));
    for (int j = 0; j < v.bp; j++) begin
      bus.rsp_ready = ~oh; #1;
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      chk("bp rsp_z", bus.rsp_z, v.ez);
      chk("bp req_ready", 32'(bus.req_ready), 0);
      nxt;
    end
    bus.rsp_ready = oh;
    nxt;
    bus.rsp_ready = 4'b0000;
    chk("post rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post busy", 32'(busy), 0);
    chk("ops_done", 32'(ops_done), 32'(v.ops));
    chk("fu_start count", 32'(nstart - s0), 1);
  endtask

  initial begin
    vec_t v;
    nvec = 0; nerr = 0;
    rst = 1'b0; fu_k = 0; fu_ret_z = '0; fu_ret_flag = '0;
    bus.req_valid = '0; bus.rsp_ready = '0;
    for (int i = 0; i < 4; i++) begin bus.req_x[i] = '0; bus.req_y[i] = '0; end

    vt[0] = '{1, 4'b0100, 32'h3F80_0000, 32'h4000_0000, 5, 32'h4040_0000, 2'b00,
              32'h4040_0000, 2'b00, 2, 6, 0, 16'd1, 0};
    for (int j = 0; j < 8; j++)
      vt[1+j] = '{(j == 0), 4'b1111, 32'h3F00_0000 + 32'(j), 32'h3E00_0000, 2 + j % 3,
                  32'h4100_0000 + 32'(j), 2'b00, 32'h4100_0000 + 32'(j), 2'b00,
                  j % 4, 3 + j % 3, 0, 16'(j + 1), 0};
    vt[9]  = '{0, 4'b1110, 32'h40A0_0000, 32'h40A0_0000, 3, 32'h4120_0000, 2'b00,
               32'h4120_0000, 2'b00, 1, 4, 10, 16'd9, 0};
    vt[10] = '{0, 4'b1111, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 2, 32'h7F80_0000, 2'b01,
               32'h7F80_0000, 2'b01, 2, 3, 0, 16'd10, 0};
    vt[11] = '{0, 4'b0001, 32'h0000_0001, 32'h8000_0000, 0, 32'h0, 2'b00,
               32'h7FC0_0000, 2'b11, 0, TO + 1, 0, 16'd11, 1};
    vt[12] = '{0, 4'b1000, 32'h0080_0000, 32'h8070_0000, 3, 32'h0010_0000, 2'b10,
               32'h0010_0000, 2'b10, 3, 4, 0, 16'd12, 1};
    vt[13] = '{1, 4'b0001, 32'h1111_1111, 32'h2222_2222, TO, 32'h1234_5678, 2'b00,
               32'h1234_5678, 2'b00, 0, TO + 1, 0, 16'd1, 0};
    vt[14] = '{0, 4'b0011, 32'h3333_3333, 32'h4444_4444, TO - 1, 32'h5555_5555, 2'b00,
               32'h5555_5555, 2'b00, 1, TO, 0, 16'd2, 0};
    vt[15] = '{0, 4'b1001, 32'h4080_0000, 32'hC080_0000, 2, 32'h0000_0000, 2'b00,
               32'h0000_0000, 2'b00, 3, 3, 0, 16'd3, 0};
    vt[16] = '{0, 4'b0101, 32'h4000_0000, 32'h4000_0000, 4, 32'h4080_0000, 2'b00,
               32'h4080_0000, 2'b00, 0, 5, 0, 16'd4, 0};

    for (int i = 0; i < 17; i++) begin
      if (vt[i].rst_b) do_reset();
      do_op(vt[i]);
    end

    // Reset while waiting on the adder; its late fu_done must be ignored.
    do_reset();
    bus.req_x[2] = 32'h3F80_0000; bus.req_y[2] = 32'h3F80_0000;
    fu_k = 5; fu_ret_z = 32'h4000_0000; fu_ret_flag = 2'b00;
    bus.req_valid = 4'b0100; #1;
    chk("rw accept", 32'(bus.req_ready), 32'h4);
    nxt; nxt; nxt;
    chk("rw busy in wait", 32'(busy), 1);
    bus.req_valid = 4'b0000;
    rst = 1'b0; #1;
    chk("rw busy in reset", 32'(busy), 0);
    chk("rw rsp_valid in reset", 32'(bus.rsp_valid), 0);
    nxt;
    rst = 1'b1;
    for (int j = 0; j < 10; j++) begin
      nxt;
      chk("rw rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rw busy", 32'(busy), 0);
    end
    chk("rw ops_done", 32'(ops_done), 0);
    chk("rw fu_start none", 32'(bus.fu_start), 0);

    // Block still serves normally afterwards.
    v = '{0, 4'b0100, 32'h3F80_0000, 32'h3F80_0000, 3, 32'h4000_0000, 2'b00,
          32'h4000_0000, 2'b00, 2, 4, 0, 16'd1, 0};
    do_op(v);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fadd_arbiter.md
FADD_ARBITER -- requirements
Module: fadd_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; the clock port SHALL be named clk and the reset port rst.
REQ-002 The block SHALL have the following parameters:
- N_REQ, default 4: number of requesters.
- TIMEOUT, default 64: maximum cycles to wait for the adder.
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  async active-low reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_x, req_y  in  N_REQ*32  IEEE-754 operands; slice i belongs to requester i.
- req_ready  out  N_REQ  one-hot request accept.
- rsp_valid  out  N_REQ  one-hot result valid.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_z  out  32  result.
- rsp_flag  out  2  status: 00 regular, 01 overflow, 10 underflow, 11 invalid.
- fu_start  out  1  one-cycle adder launch.
- fu_x, fu_y  out  32  adder operands.
- fu_done  in  1  adder result valid pulse.
- fu_z  in  32  adder result.
- fu_flag  in  2  adder status.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky adder-timeout flag.
- ops_done  out  16  completed-response counter.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; at most one operation SHALL be outstanding.
REQ-005 In IDLE with any req_valid set, the block SHALL grant round-robin: the first asserted index at or after (last_grant+1) mod N_REQ.
REQ-006 On a grant, req_ready SHALL be raised combinationally for the granted index only; req_x/req_y and the index SHALL be latched; the FSM SHALL go to ISSUE.
REQ-007 In ISSUE, fu_start SHALL be 1 for exactly one cycle; the FSM SHALL go to WAIT and clear the wait counter.
REQ-008 fu_x and fu_y SHALL hold the latched operands from ISSUE until leaving WAIT.
REQ-009 In WAIT, fu_done=1 SHALL capture fu_z and fu_flag and move the FSM to RESP.
REQ-010 In WAIT without fu_done, the wait counter SHALL increment each cycle.
REQ-011 When the wait counter reaches TIMEOUT-1 without fu_done, the block SHALL:
- load rsp_z=32'h7FC00000 and rsp_flag=11;
- set timeout_err;
- move to RESP.
REQ-012 If fu_done and the timeout condition occur in the same cycle, fu_done SHALL win.
REQ-013 fu_done outside WAIT SHALL be ignored.
REQ-014 In RESP, rsp_valid[granted] SHALL stay 1 with rsp_z and rsp_flag stable until rsp_ready[granted]=1.
REQ-015 On the RESP handshake, the block SHALL:
- update last_grant to the granted index;
- increment ops_done, wrapping 16'hFFFF to 0;
- return to IDLE.
REQ-016 rsp_ready on non-granted indices SHALL be ignored, and req_valid SHALL be ignored outside IDLE.
REQ-017 Latency SHALL be as follows: accept at cycle t, fu_start at t+1, fu_done at t+k (k>=2), rsp_valid from t+k+1; the earliest next accept is the cycle after the RESP handshake.
REQ-018 A requester dropping req_valid while not granted SHALL lose nothing; no request SHALL starve while it stays asserted, since the wait is bounded by N_REQ-1 other grants.

Reset
REQ-019 While rst=0, the block SHALL hold:
- state IDLE;
- last_grant N_REQ-1, so requester 0 wins first;
- req_ready, rsp_valid and fu_start at 0;
- fu_x, fu_y and rsp_z at 0; rsp_flag 00;
- busy 0, timeout_err 0, ops_done 0, wait counter 0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation with no rsp_valid; a later fu_done from the abandoned operation SHALL be ignored.
REQ-021 timeout_err SHALL clear only on reset.

Structure
REQ-022 Package fadd_arb_pkg SHALL hold:
- the state enum;
- FLAG_REGULAR, FLAG_OVERFLOW, FLAG_UNDERFLOW, FLAG_INVALID;
- QNAN_32 = 32'h7FC00000.
REQ-023 The grant logic SHALL be one sub-module, rr_arbiter: combinational, inputs req vector and last_grant, outputs one-hot grant and grant index.
REQ-024 The adder itself SHALL stay outside this block, connected through the fu_* ports.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Single op: requester 2 sends 0x3F800000 + 0x40000000; fu model returns 0x40400000/00 after 5 cycles -> rsp_valid[2], rsp_z=0x40400000, rsp_flag=00, ops_done=1.
- Fairness: all 4 req_valid held, 8 ops -> grant order 0,1,2,3,0,1,2,3, exactly one fu_start per op.
- Backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid[1] and rsp_z stable, no new req_ready; the next grant comes after the handshake.
- Timeout: fu_done never asserted -> rsp_flag=11 and rsp_z=0x7FC00000 at cycle t+TIMEOUT+1; timeout_err=1 until reset.
- Simultaneous: fu_done in the timeout cycle -> fu_z returned, timeout_err stays 0.
- Reset in WAIT: rst=0 for 1 cycle, then a stale fu_done -> no rsp_valid, busy=0, ops_done unchanged at 0.
